countdown_timer: RTL

- Minute:second countdown timer for the clock lab; the down-counting counterpart of the up-counting minute/hour chain.
- User sets mm:ss with increment buttons, starts/pauses with one button, and the block decrements once per 1 Hz tick.
- On reaching 00:00 the block raises an alarm for a fixed number of seconds.
- Inputs come from the existing debouncer/edge-detector: one-cycle, active-high pulses. Outputs drive the 7-seg display mux and the buzzer.

---
 rtl/countdown_pkg.sv | 21 ++
 rtl/countdown_timer_if.sv | 29 ++
 rtl/mod60_down_cnt.sv | 59 +++++
 rtl/countdown_timer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the minute:second countdown timer.
package countdown_pkg;

  // Width of the minute and second fields.
  localparam int CNT_W = 6;

  // Default wrap limit for both fields (0..59).
  localparam int MAX_VAL_DEFAULT = 59;

  // Default number of 1 Hz ticks the alarm stays up.
  localparam int ALARM_TICKS_DEFAULT = 10;

  // Timer control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Button/tick inputs and display/buzzer outputs of the countdown timer.
interface countdown_timer_if;
  import countdown_pkg::*;

  logic             tick_1hz;
  logic             start_stop;
  logic             clear;
  logic             inc_min;
  logic             inc_sec;
  logic [CNT_W-1:0] cnt_min;
  logic [CNT_W-1:0] cnt_sec;
  logic             running;
  logic             alarm;
  logic             borrow_min;
  logic             done;

  // Stimulus side: drives the pulses, observes the display/buzzer outputs.
  modport master (
    output tick_1hz, start_stop, clear, inc_min, inc_sec,
    input  cnt_min, cnt_sec, running, alarm, borrow_min, done
  );

  // Timer side.
  modport slave (
    input  tick_1hz, start_stop, clear, inc_min, inc_sec,
    output cnt_min, cnt_sec, running, alarm, borrow_min, done
  );

endinterface

// File: rtl/mod60_down_cnt.sv
// Wrapping 0..MAX_VAL up/down counter for one time field.
// borrow_o flags a decrement applied at zero so it can be chained into
// the next-higher field.
module mod60_down_cnt
  import countdown_pkg::*;
#(
  parameter int MAX_VAL = MAX_VAL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] value_o,
  output logic             zero_o,
  output logic             borrow_o
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_VAL);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  // Next field value: clear wins, then decrement, then increment.
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = {CNT_W{1'b0}};
    end else if (dec_i) begin
      if (value_q == {CNT_W{1'b0}}) begin
        value_d = MAX_V;
      end else begin
        value_d = value_q - 6'd1;
      end
    end else if (inc_i) begin
      if (value_q == MAX_V) begin
        value_d = {CNT_W{1'b0}};
      end else begin
        value_d = value_q + 6'd1;
      end
    end else begin
      value_d = value_q;
    end
  end

  // Field register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= {CNT_W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o  = value_q;
  assign zero_o   = (value_q == {CNT_W{1'b0}});
  assign borrow_o = dec_i & ~clr_i & (value_q == {CNT_W{1'b0}});

endmodule

// File: rtl/countdown_timer.sv
// Minute:second countdown timer: set with increment buttons, run/pause on
// one button, decrement once per 1 Hz tick, alarm for a fixed number of
// ticks on reaching 00:00.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int MAX_VAL     = MAX_VAL_DEFAULT,
  parameter int ALARM_TICKS = ALARM_TICKS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  countdown_timer_if.slave   bus_if
);

  localparam int               AW       = $clog2(ALARM_TICKS + 1);
  localparam logic [AW-1:0]    ALM_LAST = AW'(ALARM_TICKS - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    alm_cnt_q, alm_cnt_d;
  logic             running_q, running_d;
  logic             alarm_q, alarm_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;

  logic             clr_ev, ss_ev, tick_ev, inc_ok;
  logic             sec_inc, sec_dec, sec_borrow, sec_zero;
  logic             min_inc, min_zero;
  logic             time_zero, last_sec;
  logic [CNT_W-1:0] sec_value, min_value;

  // One event per cycle: clear > start_stop > tick > increments; losers drop.
  assign clr_ev  = bus_if.clear;
  assign ss_ev   = bus_if.start_stop & ~bus_if.clear;
  assign tick_ev = bus_if.tick_1hz & ~bus_if.clear & ~bus_if.start_stop;
  assign inc_ok  = ~bus_if.clear & ~bus_if.start_stop & ~bus_if.tick_1hz;

  assign time_zero = sec_zero & min_zero;
  assign last_sec  = min_zero & (sec_value == 6'd1);

  // Increments only in IDLE; decrement only in RUN with time left, so the
  // minute field never wraps downward.
  assign sec_inc = (state_q == ST_IDLE) & inc_ok & bus_if.inc_sec;
  assign min_inc = (state_q == ST_IDLE) & inc_ok & bus_if.inc_min;
  assign sec_dec = (state_q == ST_RUN) & tick_ev & ~time_zero;

  mod60_down_cnt #(.MAX_VAL(MAX_VAL)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (sec_inc),
    .dec_i    (sec_dec),
    .clr_i    (clr_ev),
    .value_o  (sec_value),
    .zero_o   (sec_zero),
    .borrow_o (sec_borrow)
  );

  mod60_down_cnt #(.MAX_VAL(MAX_VAL)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (min_inc),
    .dec_i    (sec_borrow),
    .clr_i    (clr_ev),
    .value_o  (min_value),
    .zero_o   (min_zero),
    .borrow_o ()
  );

  // Next state, alarm tick count and next values of the pulse/level outputs.
  always_comb begin
    state_d   = state_q;
    alm_cnt_d = alm_cnt_q;
    case (state_q)
      ST_IDLE: begin
        alm_cnt_d = {AW{1'b0}};
        if (ss_ev && !time_zero) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        alm_cnt_d = {AW{1'b0}};
        if (clr_ev) begin
          state_d = ST_IDLE;
        end else if (ss_ev) begin
          state_d = ST_PAUSE;
        end else if (tick_ev && last_sec) begin
          state_d = ST_ALARM;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        alm_cnt_d = {AW{1'b0}};
        if (clr_ev) begin
          state_d = ST_IDLE;
        end else if (ss_ev) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_ALARM: begin
        if (clr_ev || ss_ev) begin
          state_d   = ST_IDLE;
          alm_cnt_d = {AW{1'b0}};
        end else if (tick_ev) begin
          if (alm_cnt_q == ALM_LAST) begin
            state_d   = ST_IDLE;
            alm_cnt_d = {AW{1'b0}};
          end else begin
            state_d   = ST_ALARM;
            alm_cnt_d = alm_cnt_q + 1'b1;
          end
        end else begin
          state_d   = ST_ALARM;
          alm_cnt_d = alm_cnt_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        alm_cnt_d = {AW{1'b0}};
      end
    endcase

    running_d = (state_d == ST_RUN);
    alarm_d   = (state_d == ST_ALARM);
    done_d    = (state_q == ST_RUN) && (state_d == ST_ALARM);
    borrow_d  = sec_borrow;
  end

  // State, alarm tick counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      alm_cnt_q <= {AW{1'b0}};
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      borrow_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      alm_cnt_q <= alm_cnt_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
      borrow_q  <= borrow_d;
      done_q    <= done_d;
    end
  end

  assign bus_if.cnt_min    = min_value;
  assign bus_if.cnt_sec    = sec_value;
  assign bus_if.running    = running_q;
  assign bus_if.alarm      = alarm_q;
  assign bus_if.borrow_min = borrow_q;
  assign bus_if.done       = done_q;

endmodule
